frame_sequencer: RTL
====================

// Module: frame_sequencer
// PURPOSE
//   APU frame counter for the chiptune core. Divides the oscillator down to the quarter-frame rate and
//   walks a 4-step or 5-step sequence. It emits one-cycle quarter_frame and half_frame strobes that
//   schedule the envelope, length-counter and sweep updates of every voice. It also raises the frame IRQ.
//   It is configured by writes to the frame-counter register ($4017), which the serial register decoder forwards.
// PARAMETERS
//   OSCRATE    12_000_000  oscillator frequency, Hz
//   FRAMERATE  240         step rate, Hz; DIV = OSCRATE/FRAMERATE (50_000 at defaults); DIV >= 4 required
// PORTS
//   osc            in   1  system clock
//   rst_n          in   1  asynchronous active-low reset
//   reg_we         in   1  one-cycle write strobe for frame-counter register
//   reg_data       in   8  write data; bit7 = mode (0 = 4-step, 1 = 5-step); bit6 = irq_inhibit; bits 5:0 ignored
//   irq_ack        in   1  one-cycle strobe; status read acknowledges the frame IRQ
//   quarter_frame  out  1  one-cycle strobe: envelope / linear-counter clock
//   half_frame     out  1  one-cycle strobe: length-counter / sweep clock
//   irq_flag       out  1  frame interrupt flag, level
//   step           out  3  current sequence step 0..4, for debug/LED
// BEHAVIOUR
//   Reset: prescaler = 0, step = 0, mode = 0, irq_inhibit = 0, all outputs 0. Reset is honoured mid-sequence at any cycle.
//   Prescaler: counts 0..DIV-1 and wraps to 0. tick = (prescaler == DIV-1).
//   Sequencer: advances on tick. Strobes and step are registered, so a strobe is high in the cycle after the tick cycle.
//   4-step (mode = 0):
//     S0 -> Q
//     S1 -> Q+H
//     S2 -> Q
//     S3 -> Q+H, and set irq_flag if !irq_inhibit
//     then wraps to S0
//   5-step (mode = 1):
//     S0 -> Q
//     S1 -> Q+H
//     S2 -> Q
//     S3 -> none
//     S4 -> Q+H
//     then wraps to S0; no IRQ is generated
//   step output = index of the last step executed; it is 0 after reset or a write.
//   Register write: 1-cycle latency. In the cycle after reg_we:
//     - mode and irq_inhibit are latched, prescaler = 0, step = 0.
//     - If mode = 1, Q and H are both strobed in that cycle (immediate clock).
//     - If irq_inhibit = 1, irq_flag is cleared in that cycle.
//   Simultaneous events:
//     - reg_we with tick: the write wins; the tick is discarded and no step strobe is emitted.
//     - irq_ack with an IRQ set: the set wins, so irq_flag stays 1.
//     - irq_ack alone: irq_flag = 0 on the next cycle.
//   Width: prescaler is $clog2(DIV) bits; step is 3 bits. Step never exceeds 3 in 4-step mode or 4 in 5-step mode.
//     A mode change mid-sequence always restarts at S0, so a stale out-of-range step cannot occur.
// CONFIGURATION
//   FRAME_IRQ_EN defined: IRQ logic as above.
//   FRAME_IRQ_EN undefined: irq_flag is tied to 0, irq_ack and reg_data[6] are ignored, and no flag register is built.
//     Strobes and step are identical in both builds.
// STRUCTURE
//   chiptune_pkg (shared): step encodings S0..S4, MODE_BIT = 7, INHIBIT_BIT = 6, STEP_W = 3.
//   Sub-module tick_divider: parameter DIV; inputs osc, rst_n, clear; output tick. It holds the prescaler.
//     clear = reg_we. This divider is reused for the blink/baud dividers.
//   frame_sequencer holds the mode/inhibit registers, the step FSM and the IRQ flag.
// TESTING  (sim build OSCRATE=2400, FRAMERATE=240 -> DIV=10)
//   1. Reset release, mode 0:
//        Q strobes at cycles 10, 20, 30, 40; H strobes at 20, 40.
//        irq_flag rises at 40 (with FRAME_IRQ_EN); step sequence 0, 1, 2, 3, 0.
//   2. Write 0x80:
//        Q = H = 1 in the cycle after the write.
//        Then Q at +10, +20, +30, +50 and H at +20, +50; no strobe at +40; irq_flag stays 0 over 100 cycles.
//   3. irq_flag = 1, then write 0x40: irq_flag = 0 next cycle and stays 0 through two full sequences.
//   4. irq_ack asserted on the same cycle the S3 IRQ sets: irq_flag = 1.
//      irq_ack pulsed 5 cycles later: irq_flag = 0.
//   5. reg_we = 0x00 on the exact tick cycle: no Q/H strobe; the next Q is 10 cycles after the write; step = 0.
//   6. rst_n pulsed low at S2 mid-prescale: all outputs 0 immediately.
//      After release, the sequence restarts as in test 1; without FRAME_IRQ_EN, irq_flag is 0 in all tests.

Source files
------------

// File: rtl/chiptune_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module      : chiptune_pkg                                                  |
// | Description : Shared frame-sequencer step encodings and register bit map.   |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

package chiptune_pkg;

    localparam int STEP_W      = 3;
    localparam int MODE_BIT    = 7;
    localparam int INHIBIT_BIT = 6;

    typedef enum logic [STEP_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } step_e;

    // Successor of a step; the 4-step sequence wraps after S3, the 5-step after S4.
    function automatic step_e next_step(input step_e s, input logic mode5);
        case (s)
            S0:      return S1;
            S1:      return S2;
            S2:      return S3;
            S3:      return mode5 ? S4 : S0;
            default: return S0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_sequencer_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : frame_sequencer_if                                            |
// | Description : Register-write / strobe bundle between decoder and sequencer. |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface frame_sequencer_if;
    import chiptune_pkg::*;

    logic              reg_we;
    logic [7:0]        reg_data;
    logic              irq_ack;
    logic              quarter_frame;
    logic              half_frame;
    logic              irq_flag;
    logic [STEP_W-1:0] step;

    modport master (
        output reg_we, reg_data, irq_ack,
        input  quarter_frame, half_frame, irq_flag, step
    );

    modport slave (
        input  reg_we, reg_data, irq_ack,
        output quarter_frame, half_frame, irq_flag, step
    );

endinterface

`default_nettype wire

// File: rtl/tick_divider.sv
// +-----------------------------------------------------------------------------+
// | Module      : tick_divider                                                  |
// | Description : Free-running 0..DIV-1 prescaler with synchronous clear.       |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tick_divider #(
    parameter int DIV = 50_000
) (
    input  wire logic osc,
    input  wire logic rst_n,
    input  wire logic clear,
    output logic      tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module      : frame_sequencer                                               |
// | Description : APU frame counter: 4/5-step quarter/half-frame strobes + IRQ. |
// |               Optional frame IRQ built only when FRAME_IRQ_EN is defined.   |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
`default_nettype none

module frame_sequencer
    import chiptune_pkg::*;
#(
    parameter int OSCRATE   = 12_000_000,
    parameter int FRAMERATE = 240
) (
    input  wire logic        osc,
    input  wire logic        rst_n,
    frame_sequencer_if.slave bus
);

    localparam int DIV = OSCRATE / FRAMERATE;

    logic              tick;
    step_e             nxt_q, nxt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              mode_q, mode_d;
    logic              qf_q, qf_d;
    logic              hf_q, hf_d;

    tick_divider #(.DIV(DIV)) u_tick_divider (
        .osc   (osc),
        .rst_n (rst_n),
        .clear (bus.reg_we),
        .tick  (tick)
    );

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            nxt_q  <= S0;
            step_q <= '0;
            mode_q <= 1'b0;
            qf_q   <= 1'b0;
            hf_q   <= 1'b0;
        end else begin
            nxt_q  <= nxt_d;
            step_q <= step_d;
            mode_q <= mode_d;
            qf_q   <= qf_d;
            hf_q   <= hf_d;
        end
    end

    // nxt_q is the step the next tick executes; step_q shows the one last executed.
    always_comb begin
        nxt_d  = nxt_q;
        step_d = step_q;
        mode_d = mode_q;
        qf_d   = 1'b0;
        hf_d   = 1'b0;
        if (bus.reg_we) begin
            mode_d = bus.reg_data[MODE_BIT];
            nxt_d  = S0;
            step_d = '0;
            qf_d   = bus.reg_data[MODE_BIT];
            hf_d   = bus.reg_data[MODE_BIT];
        end else if (tick) begin
            step_d = nxt_q;
            nxt_d  = next_step(nxt_q, mode_q);
            case (nxt_q)
                S0, S2:  qf_d = 1'b1;
                S1, S4:  begin qf_d = 1'b1; hf_d = 1'b1; end
                S3:      begin qf_d = !mode_q; hf_d = !mode_q; end
                default: ;
            endcase
        end
    end

    assign bus.quarter_frame = qf_q;
    assign bus.half_frame    = hf_q;
    assign bus.step          = step_q;

`ifdef FRAME_IRQ_EN
    logic inhibit_q, inhibit_d;
    logic irq_q, irq_d;
    logic irq_set;
    logic unused_reg_bits;

    always_comb begin
        inhibit_d = inhibit_q;
        irq_d     = irq_q;
        irq_set   = !bus.reg_we && tick && (nxt_q == S3) && !mode_q && !inhibit_q;
        if (bus.reg_we) begin
            inhibit_d = bus.reg_data[INHIBIT_BIT];
        end
        // A set in the same cycle as an acknowledge keeps the flag high.
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack || (bus.reg_we && bus.reg_data[INHIBIT_BIT])) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.irq_flag    = irq_q;
    assign unused_reg_bits = ^bus.reg_data[5:0];
`else
    logic unused_reg_bits;

    assign bus.irq_flag    = 1'b0;
    assign unused_reg_bits = ^{bus.reg_data[6:0], bus.irq_ack};
`endif

endmodule

`default_nettype wire
